// File: rtl/digit_serial_sub.sv
// digit_serial_sub: A - B - Bin over WIDTH bits, DIGIT bits per clock, LSB digit first.
// Operands arrive and results leave through valid/ready handshakes.
// Optional feature macro: DIGIT_SERIAL_SUB_SAT_EN (unsigned saturation to zero on underflow).
module digit_serial_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic             in_Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_Diff,
  output logic             out_Bout,
  output logic             out_Zero
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Reject parameter combinations that do not split into whole digits
  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("digit_serial_sub: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             load, last;
  logic [DIGIT:0]   dig;
  logic [WIDTH-1:0] res_nxt, diff_fin;

  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign load     = in_valid & in_ready;
  assign last     = (cnt == CW'(NDIG - 1));

  // One digit of subtraction; the top bit of the (DIGIT+1)-bit result is the borrow out
  assign dig      = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - (DIGIT+1)'(borrow);
  assign res_nxt  = (res_sh >> DIGIT) | (WIDTH'(dig[DIGIT-1:0]) << (WIDTH - DIGIT));

  // Final result as presented, clamped to zero on underflow when saturation is built in
`ifdef DIGIT_SERIAL_SUB_SAT_EN
  assign diff_fin = dig[DIGIT] ? '0 : res_nxt;
`else
  assign diff_fin = res_nxt;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/result shift registers, chained borrow and digit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sh   <= in_A;
      b_sh   <= in_B;
      res_sh <= '0;
      borrow <= in_Bin;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      res_sh <= res_nxt;
      borrow <= dig[DIGIT];
      cnt    <= last ? '0 : cnt + CW'(1);
    end
  end

  // Result registers: loaded on the last digit, frozen until the next operation completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_Diff  <= '0;
      out_Bout  <= 1'b0;
      out_Zero  <= 1'b0;
    end else begin
      out_valid <= (state_nxt == DONE);
      if (state == RUN && last) begin
        out_Diff <= diff_fin;
        out_Bout <= dig[DIGIT];
        out_Zero <= (diff_fin == '0);
      end
    end
  end

endmodule
